// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state type and sizing/encoding helpers for the keypad scanner
package keypad_pkg;

    typedef enum logic [2:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        HOLD,
        RELEASE
    } state_t;

    // Widest vector lowest_set() accepts; callers zero-extend into it.
    localparam int LSB_MAXW = 32;

    // Index of the lowest set bit (0 when no bit is set).
    function automatic int lowest_set(input logic [LSB_MAXW-1:0] v);
        int idx;
        idx = 0;
        for (int i = LSB_MAXW - 1; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

    // Width of key_code for an nrows x ncols matrix (at least 1 bit).
    function automatic int code_width(input int nrows, input int ncols);
        int n;
        n = nrows * ncols;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Shared width for the hold, debounce and repeat counters.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/keypad_debounce_cnt.sv
// rtl/keypad_debounce_cnt.sv - saturating up-counter with clear, enable and terminal-count flag
//
// Ports:
//   clk, reset   clock and asynchronous active-low reset
//   clr          synchronous clear (wins over en)
//   en           count up by one, stopping at TERMINAL
//   tc           high while the count equals TERMINAL
module keypad_debounce_cnt #(
    parameter int WIDTH    = 4,
    parameter int TERMINAL = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != TC_VAL)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/keypad_scan_fsm.sv
// rtl/keypad_scan_fsm.sv - row-strobe keypad scanner with press/release debounce
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   col        raw column returns, active-high, asynchronous to clk
//   row        one-hot row strobe, active-high
//   key_valid  one-cycle pulse per debounced press
//   key_code   row_idx*NCOLS + col_idx of the last valid key
//   key_held   high while the debounced key is down
//
// Build option: KEYPAD_AUTOREPEAT_EN adds a key_valid pulse every
// REPEAT_CYCLES cycles spent in HOLD.
module keypad_scan_fsm
    import keypad_pkg::*;
#(
    parameter int NROWS           = 4,
    parameter int NCOLS           = 4,
    parameter int SCAN_HOLD       = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NCOLS-1:0]                    col,
    output logic [NROWS-1:0]                    row,
    output logic                                key_valid,
    output logic [code_width(NROWS, NCOLS)-1:0] key_code,
    output logic                                key_held
);
    localparam int KW   = code_width(NROWS, NCOLS);
    localparam int CIW  = (NCOLS > 1) ? $clog2(NCOLS) : 1;
    localparam int CNTW = cnt_width(SCAN_HOLD, DEBOUNCE_CYCLES, REPEAT_CYCLES);

    // The last hold cycle must already see this row's columns through both sync flops.
    if (SCAN_HOLD < 3) begin : g_hold_check
        $error("keypad_scan_fsm: SCAN_HOLD must be >= 3");
    end

    state_t           state, state_n;
    logic [NCOLS-1:0] col_m, col_s;
    logic [NROWS-1:0] row_n, row_adv;
    logic [CIW-1:0]   col_idx, col_idx_n;
    logic [KW-1:0]    key_code_n;
    logic             key_valid_n, key_held_n;
    logic             col_bit;
    logic             hold_clr, hold_en, hold_tc;
    logic             deb_clr, deb_en, deb_tc;
    logic             rep_fire;

    assign col_bit = col_s[col_idx];
    // Rotate left with wrap; also correct for a single-row matrix.
    assign row_adv = (row << 1) | (row >> (NROWS - 1));

    keypad_debounce_cnt #(.WIDTH(CNTW), .TERMINAL(SCAN_HOLD - 1)) u_hold_cnt (
        .clk(clk), .reset(reset), .clr(hold_clr), .en(hold_en), .tc(hold_tc)
    );

    // Shared by press debounce and release debounce; tc marks the cycle
    // whose stable sample completes DEBOUNCE_CYCLES.
    keypad_debounce_cnt #(.WIDTH(CNTW), .TERMINAL(DEBOUNCE_CYCLES - 1)) u_deb_cnt (
        .clk(clk), .reset(reset), .clr(deb_clr), .en(deb_en), .tc(deb_tc)
    );

`ifdef KEYPAD_AUTOREPEAT_EN
    logic rep_clr, rep_en, rep_tc;

    // Runs only in HOLD, so a release glitch pauses it rather than restarting it.
    assign rep_en   = (state == HOLD);
    assign rep_fire = (state == HOLD) && rep_tc;
    assign rep_clr  = (state == PRESSED) || rep_fire;

    keypad_debounce_cnt #(.WIDTH(CNTW), .TERMINAL(REPEAT_CYCLES - 1)) u_rep_cnt (
        .clk(clk), .reset(reset), .clr(rep_clr), .en(rep_en), .tc(rep_tc)
    );
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        row_n      = row;
        col_idx_n  = col_idx;
        key_code_n = key_code;
        hold_clr   = 1'b1;
        hold_en    = 1'b0;
        deb_clr    = 1'b1;
        deb_en     = 1'b0;
        unique case (state)
            SCAN: begin
                hold_en  = 1'b1;
                hold_clr = hold_tc;
                if (hold_tc) begin
                    if (col_s != '0) begin
                        col_idx_n = CIW'(lowest_set(LSB_MAXW'(col_s)));
                        state_n   = DEBOUNCE;
                    end else begin
                        row_n = row_adv;
                    end
                end
            end
            DEBOUNCE: begin
                deb_clr = 1'b0;
                deb_en  = col_bit;
                if (!col_bit) begin
                    state_n = SCAN;
                    row_n   = row_adv;
                end else if (deb_tc) begin
                    state_n    = PRESSED;
                    key_code_n = KW'(lowest_set(LSB_MAXW'(row)) * NCOLS + int'(col_idx));
                end
            end
            PRESSED: state_n = HOLD;
            HOLD: begin
                if (!col_bit) state_n = RELEASE;
            end
            RELEASE: begin
                deb_clr = col_bit;
                deb_en  = !col_bit;
                if (col_bit) begin
                    state_n = HOLD;
                end else if (deb_tc) begin
                    state_n = SCAN;
                    row_n   = row_adv;
                end
            end
            default: state_n = SCAN;
        endcase
        // Outputs are registered from the next state so they line up with it.
        key_valid_n = (state_n == PRESSED) || rep_fire;
        key_held_n  = (state_n == PRESSED) || (state_n == HOLD) || (state_n == RELEASE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_m     <= '0;
            col_s     <= '0;
            state     <= SCAN;
            row       <= NROWS'(1);
            col_idx   <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
            key_held  <= 1'b0;
        end else begin
            col_m     <= col;
            col_s     <= col_m;
            state     <= state_n;
            row       <= row_n;
            col_idx   <= col_idx_n;
            key_valid <= key_valid_n;
            key_code  <= key_code_n;
            key_held  <= key_held_n;
        end
    end

endmodule

// File: tb/tb_keypad_scan_fsm.sv
// tb/tb_keypad_scan_fsm.sv - self-checking bench for keypad_scan_fsm against a virtual keypad
module tb_keypad_scan_fsm;
    localparam int NR   = 4;
    localparam int NC   = 4;
    localparam int H    = 4;
    localparam int D    = 4;
    localparam int R    = 8;
    localparam int KW   = 4;
    localparam int LOGN = 2048;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic [NC-1:0] col   = '0;
    logic [NR-1:0] row;
    logic          key_valid;
    logic [KW-1:0] key_code;
    logic          key_held;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [NR*NC-1:0] keys = '0;
    logic [NR-1:0]    row_at  [LOGN];
    logic             held_at [LOGN];
    int               vq[$];
    int               cq[$];

    keypad_scan_fsm #(
        .NROWS(NR), .NCOLS(NC), .SCAN_HOLD(H), .DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)
    ) dut (
        .clk(clk), .reset(reset), .col(col), .row(row),
        .key_valid(key_valid), .key_code(key_code), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Closed keys connect the driven row to their column.
    function automatic logic [NC-1:0] pad_cols(input logic [NR-1:0] r, input logic [NR*NC-1:0] k);
        logic [NC-1:0] c;
        c = '0;
        for (int i = 0; i < NR; i++) if (r[i]) c |= k[i*NC +: NC];
        return c;
    endfunction

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Cycle n = interval after the n-th clock edge since reset release.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc < LOGN) begin
            row_at[cyc]  = row;
            held_at[cyc] = key_held;
        end
        if (key_valid) begin
            vq.push_back(cyc);
            cq.push_back(int'(key_code));
        end
        col = pad_cols(row, keys);
    endtask

    task automatic run_until(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset(input logic [NR*NC-1:0] k);
        reset = 1'b0;
        keys  = k;
        col   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
        vq.delete();
        cq.delete();
        row_at[0]  = row;
        held_at[0] = key_held;
        col = pad_cols(row, keys);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        keys  = '1;
        col   = '1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (row !== onehot(0)) begin errors++; $display("FAIL reset_row: got %b expected %b", row, onehot(0)); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b expected 0", key_held); end
        checks++; if (key_code !== '0) begin errors++; $display("FAIL reset_code: got %0d expected 0", key_code); end
    endtask

    task automatic test_idle_scan();
        do_reset('0);
        run_until(2 * NR * H + 2);
        for (int t = 0; t <= 2 * NR * H + 1; t++) begin
            checks++;
            if (row_at[t] !== onehot((t / H) % NR)) begin
                errors++;
                $display("FAIL idle_row cycle %0d: got %b expected %b", t, row_at[t], onehot((t / H) % NR));
            end
        end
        checks++; if (vq.size() != 0) begin errors++; $display("FAIL idle_pulses: got %0d expected 0", vq.size()); end
    endtask

    task automatic test_single_press();
        for (int it = 0; it < 3; it++) begin
            int r, c, p;
            int exp_q[$];
            logic [NR*NC-1:0] k;
            r = (it == 0) ? 2 : int'($urandom_range(0, NR - 1));
            c = (it == 0) ? 1 : int'($urandom_range(0, NC - 1));
            k = '0;
            k[r*NC + c] = 1'b1;
            do_reset(k);
            p = r * H + H - 1 + D + 1;
            exp_q.push_back(p);
`ifdef KEYPAD_AUTOREPEAT_EN
            for (int t = p + R + 1; t <= p + 50; t += R) exp_q.push_back(t);
`endif
            run_until(p + 50);
            checks++;
            if (vq.size() != exp_q.size()) begin
                errors++; $display("FAIL press_count key %0d: got %0d expected %0d", r*NC + c, vq.size(), exp_q.size());
            end else begin
                for (int j = 0; j < exp_q.size(); j++) begin
                    checks++; if (vq[j] != exp_q[j]) begin errors++; $display("FAIL press_time #%0d: got %0d expected %0d", j, vq[j], exp_q[j]); end
                    checks++; if (cq[j] != r*NC + c) begin errors++; $display("FAIL press_code #%0d: got %0d expected %0d", j, cq[j], r*NC + c); end
                end
            end
            checks++; if (held_at[p-1] !== 1'b0 || held_at[p] !== 1'b1) begin errors++; $display("FAIL press_held_edge: got %b%b expected 01", held_at[p-1], held_at[p]); end
            checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press_held_end: got %b expected 1", key_held); end
            checks++; if (row !== onehot(r)) begin errors++; $display("FAIL press_row_frozen: got %b expected %b", row, onehot(r)); end
        end
    endtask

    task automatic test_bounce();
        for (int it = 0; it < 3; it++) begin
            int r, c, b, t0, held_cnt;
            logic [NR*NC-1:0] k;
            r = (it == 0) ? 2 : int'($urandom_range(0, NR - 1));
            c = (it == 0) ? 1 : int'($urandom_range(0, NC - 1));
            b = (it == 0) ? 2 : ((it == 1) ? D : int'($urandom_range(1, D)));
            k = '0;
            k[r*NC + c] = 1'b1;
            do_reset(k);
            t0 = r * H + H - 1;
            // Synchronised column stays high for b cycles starting at the scan sample.
            run_until(t0 + b - 3);
            keys = '0;
            run_until(t0 + b + 1 + H);
            held_cnt = 0;
            for (int t = 0; t <= cyc; t++) if (held_at[t] === 1'b1) held_cnt++;
            checks++; if (vq.size() != 0) begin errors++; $display("FAIL bounce_pulses b=%0d: got %0d expected 0", b, vq.size()); end
            checks++; if (held_cnt != 0) begin errors++; $display("FAIL bounce_held b=%0d: got %0d cycles expected 0", b, held_cnt); end
            checks++; if (row_at[t0 + b] !== onehot(r)) begin errors++; $display("FAIL bounce_row_frozen: got %b expected %b", row_at[t0 + b], onehot(r)); end
            checks++; if (row_at[t0 + b + 1] !== onehot((r + 1) % NR)) begin errors++; $display("FAIL bounce_row_next: got %b expected %b", row_at[t0 + b + 1], onehot((r + 1) % NR)); end
            checks++; if (row_at[t0 + b + 1 + H] !== onehot((r + 2) % NR)) begin errors++; $display("FAIL bounce_row_after: got %b expected %b", row_at[t0 + b + 1 + H], onehot((r + 2) % NR)); end
        end
    endtask

    task automatic test_release_glitch();
        int r, c, p, a;
        logic [NR*NC-1:0] k;
        r = int'($urandom_range(0, NR - 1));
        c = int'($urandom_range(0, NC - 1));
        k = '0;
        k[r*NC + c] = 1'b1;
        do_reset(k);
        p = r * H + H - 1 + D + 1;
        a = p + 3;
        // Raw column: low 2, high 1, then low for good.
        run_until(a - 1);
        keys = '0;
        run_until(a + 1);
        keys = k;
        run_until(a + 2);
        keys = '0;
        run_until(a + 6 + D + H);
        checks++; if (held_at[a + 4] !== 1'b1) begin errors++; $display("FAIL glitch_held_mid: got %b expected 1", held_at[a + 4]); end
        checks++; if (held_at[a + 5 + D] !== 1'b1) begin errors++; $display("FAIL glitch_held_last: got %b expected 1", held_at[a + 5 + D]); end
        checks++; if (held_at[a + 6 + D] !== 1'b0) begin errors++; $display("FAIL glitch_held_drop: got %b expected 0", held_at[a + 6 + D]); end
        checks++; if (row_at[a + 5 + D] !== onehot(r)) begin errors++; $display("FAIL glitch_row_frozen: got %b expected %b", row_at[a + 5 + D], onehot(r)); end
        checks++; if (row_at[a + 6 + D] !== onehot((r + 1) % NR)) begin errors++; $display("FAIL glitch_row_next: got %b expected %b", row_at[a + 6 + D], onehot((r + 1) % NR)); end
        checks++; if (vq.size() != 1) begin errors++; $display("FAIL glitch_pulses: got %0d expected 1", vq.size()); end
        checks++; if (int'(key_code) != r*NC + c) begin errors++; $display("FAIL glitch_code_stable: got %0d expected %0d", key_code, r*NC + c); end
    endtask

    task automatic test_multikey_reset();
        for (int it = 0; it < 3; it++) begin
            int r, p, low, code;
            logic [NC-1:0] m;
            logic [NR*NC-1:0] k;
            r = (it == 0) ? 0 : int'($urandom_range(0, NR - 1));
            m = (it == 0) ? NC'(6) : NC'($urandom_range(1, (1 << NC) - 1));
            low = 0;
            for (int i = NC - 1; i >= 0; i--) if (m[i]) low = i;
            code = r * NC + low;
            k = '0;
            k[r*NC +: NC] = m;
            do_reset(k);
            p = r * H + H - 1 + D + 1;
            run_until(p + 5);
            checks++; if (vq.size() != 1) begin errors++; $display("FAIL multi_pulses cols %b: got %0d expected 1", m, vq.size()); end
            checks++; if (int'(key_code) != code) begin errors++; $display("FAIL multi_code cols %b: got %0d expected %0d", m, key_code, code); end
            checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL multi_held: got %b expected 1", key_held); end
            // Assert reset between clock edges; outputs must clear without an edge.
            #2;
            reset = 1'b0;
            #1;
            checks++; if (row !== onehot(0)) begin errors++; $display("FAIL async_row: got %b expected %b", row, onehot(0)); end
            checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL async_held: got %b expected 0", key_held); end
            checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b expected 0", key_valid); end
        end
    endtask

`ifdef KEYPAD_AUTOREPEAT_EN
    task automatic test_autorepeat();
        int r, c, p;
        int exp_q[$];
        logic [NR*NC-1:0] k;
        r = int'($urandom_range(0, NR - 1));
        c = int'($urandom_range(0, NC - 1));
        k = '0;
        k[r*NC + c] = 1'b1;
        do_reset(k);
        p = r * H + H - 1 + D + 1;
        exp_q = '{p, p + R + 1, p + 2*R + 1, p + 3*R + 1};
        run_until(p + 27);
        keys = '0;
        run_until(p + 28 + 3 + D + H + 2);
        checks++;
        if (vq.size() != exp_q.size()) begin
            errors++; $display("FAIL repeat_count: got %0d expected %0d", vq.size(), exp_q.size());
        end else begin
            for (int j = 0; j < exp_q.size(); j++) begin
                checks++; if (vq[j] != exp_q[j]) begin errors++; $display("FAIL repeat_time #%0d: got %0d expected %0d", j, vq[j], exp_q[j]); end
                checks++; if (cq[j] != r*NC + c) begin errors++; $display("FAIL repeat_code #%0d: got %0d expected %0d", j, cq[j], r*NC + c); end
            end
        end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL repeat_released: got %b expected 0", key_held); end
    endtask
`endif

    initial begin
        test_reset();
        test_idle_scan();
        test_single_press();
        test_bounce();
        test_release_glitch();
        test_multikey_reset();
`ifdef KEYPAD_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
